// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: bit_tick fires once every CLKS_PER_BIT cycles after clear.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Zero is the reload phase, so a cleared timer runs 0, C-1, ..., 1 and ticks on 1.
    assign bit_tick = (r_count == TICK_AT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (r_count == '0) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and sends them as 8N1/8N2 frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_req,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int               IDX_W     = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shreg_next;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [IDX_W-1:0]      w_bit_idx_next;
    logic                  r_stop_idx;
    logic                  w_stop_idx_next;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  w_timer_clear;
    logic                  w_bit_tick;
    logic                  w_tx_done;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_timer_clear),
        .bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_tx       <= w_tx_next;
        end
    end

    always_ff @(posedge clk) begin
        r_shreg <= w_shreg_next;
    end

    always_comb begin
        w_state_next    = r_state;
        w_shreg_next    = r_shreg;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_timer_clear   = 1'b0;
        w_tx_done       = 1'b0;

        case (r_state)
            IDLE: begin
                if (!fifo_empty) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_state_next = LOAD;
            end
            LOAD: begin
                w_shreg_next    = fifo_data;
                w_bit_idx_next  = '0;
                w_stop_idx_next = 1'b0;
                w_timer_clear   = 1'b1;
                w_state_next    = START;
            end
            START: begin
                if (w_bit_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_shreg_next = r_shreg >> 1;
                    if (r_bit_idx == BIT_LAST) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    if (r_stop_idx == STOP_LAST) begin
                        w_tx_done    = 1'b1;
                        w_state_next = fifo_empty ? IDLE : FETCH;
                    end else begin
                        w_stop_idx_next = r_stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // tx is registered, so it is derived from where the FSM is heading next.
    always_comb begin
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shreg_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx          = r_tx;
    assign busy        = (r_state != IDLE);
    assign fifo_rd_req = (r_state == FETCH);
    assign tx_done     = w_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (1 and 2 stop bits) fed by FIFO models.
module tb_uart_tx;

    localparam int C = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] mem1 [64];
    logic [7:0] mem2 [64];
    int         wr1 = 0, rp1 = 0, wr2 = 0, rp2 = 0;
    int         uflow1 = 0, uflow2 = 0;
    logic       empty1, empty2;
    logic [7:0] fdata1, fdata2;
    logic       rd1, tx1, busy1, done1;
    logic       rd2, tx2, busy2, done2;

    assign empty1 = (wr1 == rp1);
    assign empty2 = (wr2 == rp2);

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(empty1), .fifo_data(fdata1),
        .fifo_rd_req(rd1), .tx(tx1), .busy(busy1), .tx_done(done1));

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .fifo_empty(empty2), .fifo_data(fdata2),
        .fifo_rd_req(rd2), .tx(tx2), .busy(busy2), .tx_done(done2));

    always @(posedge clk) begin
        if (rd1) begin
            if (empty1) uflow1 <= uflow1 + 1;
            else begin
                fdata1 <= mem1[rp1 % 64];
                rp1    <= rp1 + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rd2) begin
            if (empty2) uflow2 <= uflow2 + 1;
            else begin
                fdata2 <= mem2[rp2 % 64];
                rp2    <= rp2 + 1;
            end
        end
    end

    logic [7:0] stim_q [$];
    logic [3:0] exp_q  [$];   // {tx, fifo_rd_req, tx_done, busy} per cycle
    logic [3:0] cap_q  [$];
    int vectors = 0;
    int miscompares = 0;

    task automatic push_stim(input bit sel);
        foreach (stim_q[i]) begin
            if (sel) begin mem2[wr2 % 64] = stim_q[i]; wr2++; end
            else     begin mem1[wr1 % 64] = stim_q[i]; wr1++; end
        end
    endtask

    // Reference: bytes queued at once into an idle transmitter -> per-cycle outputs.
    function automatic void build_model(input int s);
        logic lvl, last;
        exp_q.delete();
        for (int n = 0; n < stim_q.size(); n++) begin
            exp_q.push_back(4'b1101);
            exp_q.push_back(4'b1001);
            for (int p = 0; p < 9 + s; p++) begin
                lvl = (p == 0) ? 1'b0 : (p <= 8) ? stim_q[n][p-1] : 1'b1;
                for (int c = 0; c < C; c++) begin
                    last = (p == 8 + s) && (c == C - 1);
                    exp_q.push_back({lvl, 1'b0, last, 1'b1});
                end
            end
        end
        for (int t = 0; t < 4; t++) exp_q.push_back(4'b1000);
    endfunction

    task automatic capture(input bit sel, input int n);
        cap_q.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cap_q.push_back(sel ? {tx2, rd2, done2, busy2} : {tx1, rd1, done1, busy1});
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({tx1, rd1, done1, busy1, tx2, rd2, done2, busy2} !== 8'b1000_1000) begin
            miscompares++;
            $display("FAIL reset_state got %b want 10001000", {tx1, rd1, done1, busy1, tx2, rd2, done2, busy2});
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({tx1, rd1, done1, busy1, tx2, rd2, done2, busy2} !== 8'b1000_1000) begin
                miscompares++;
                $display("FAIL idle_empty cycle %0d got %b want 10001000", i, {tx1, rd1, done1, busy1, tx2, rd2, done2, busy2});
            end
        end
    endtask

    task automatic test_single_byte;
        logic [9:0] seq;
        int fall, done_i, nrd, ndone;
        seq = 10'b11_0100_1010;
        stim_q = '{8'hA5};
        push_stim(1'b0);
        build_model(1);
        capture(1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (cap_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL a5_trace cycle %0d got %b want %b", i, cap_q[i], exp_q[i]);
            end
        end
        fall = -1; done_i = -1; nrd = 0; ndone = 0;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (fall < 0 && cap_q[i][3] === 1'b0) fall = i;
            if (cap_q[i][1] === 1'b1) begin ndone++; done_i = i; end
            if (cap_q[i][2] === 1'b1) nrd++;
        end
        vectors++;
        if (nrd != 1 || ndone != 1) begin
            miscompares++;
            $display("FAIL a5_pulses rd=%0d done=%0d want 1 and 1", nrd, ndone);
        end
        vectors++;
        if (fall < 0 || done_i - fall + 1 != 40) begin
            miscompares++;
            $display("FAIL a5_done_pos got span %0d want 40", done_i - fall + 1);
        end
        if (fall >= 0 && fall + 39 < cap_q.size()) begin
            for (int b = 0; b < 10; b++) begin
                vectors++;
                if (cap_q[fall + 4*b + 2][3] !== seq[b]) begin
                    miscompares++;
                    $display("FAIL a5_bit %0d got %b want %b", b, cap_q[fall + 4*b + 2][3], seq[b]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int d0, nrd, ndone;
        stim_q = '{8'h00, 8'hFF};
        push_stim(1'b0);
        build_model(1);
        capture(1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (cap_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_trace cycle %0d got %b want %b", i, cap_q[i], exp_q[i]);
            end
        end
        d0 = -1; nrd = 0; ndone = 0;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (cap_q[i][1] === 1'b1) begin ndone++; if (d0 < 0) d0 = i; end
            if (cap_q[i][2] === 1'b1) nrd++;
        end
        vectors++;
        if (nrd != 2 || ndone != 2) begin
            miscompares++;
            $display("FAIL b2b_pulses rd=%0d done=%0d want 2 and 2", nrd, ndone);
        end
        vectors++;
        if (d0 < 0 || d0 + 3 >= cap_q.size() ||
            {cap_q[d0+1][3], cap_q[d0+2][3], cap_q[d0+3][3], cap_q[d0+1][0], cap_q[d0+2][0]} !== 5'b11011) begin
            miscompares++;
            $display("FAIL b2b_gap first_done=%0d got tx/busy pattern mismatch want 2 high gap cycles busy", d0);
        end
    endtask

    task automatic test_reset_mid_frame;
        stim_q = '{8'h3C, 8'h81};
        push_stim(1'b0);
        for (int k = 1; k <= 20; k++) begin @(posedge clk); #1; end
        vectors++;
        if ({tx1, busy1} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_bit3 got tx=%b busy=%b want 1 1", tx1, busy1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({tx1, rd1, done1, busy1} !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_reset got %b want 1000", {tx1, rd1, done1, busy1});
        end
        reset = 1'b0;
        stim_q = '{8'h81};
        build_model(1);
        capture(1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (cap_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL mid_resume cycle %0d got %b want %b", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stop2;
        int fall, done_i;
        stim_q = '{8'h55};
        push_stim(1'b1);
        build_model(2);
        capture(1'b1, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (cap_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stop2_trace cycle %0d got %b want %b", i, cap_q[i], exp_q[i]);
            end
        end
        fall = -1; done_i = -1;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (fall < 0 && cap_q[i][3] === 1'b0) fall = i;
            if (cap_q[i][1] === 1'b1) done_i = i;
        end
        vectors++;
        if (fall < 0 || done_i - fall + 1 != 44) begin
            miscompares++;
            $display("FAIL stop2_span got %0d want 44", done_i - fall + 1);
        end
    endtask

    task automatic test_fifo16;
        int fall, done_i, nrd;
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(i));
        push_stim(1'b0);
        build_model(1);
        capture(1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (cap_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL fifo16_trace cycle %0d got %b want %b", i, cap_q[i], exp_q[i]);
            end
        end
        fall = -1; done_i = -1; nrd = 0;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (fall < 0 && cap_q[i][3] === 1'b0) fall = i;
            if (cap_q[i][1] === 1'b1) done_i = i;
            if (cap_q[i][2] === 1'b1) nrd++;
        end
        vectors++;
        if (fall < 0 || done_i - fall + 1 != 16*40 + 15*2) begin
            miscompares++;
            $display("FAIL fifo16_span got %0d want %0d", done_i - fall + 1, 16*40 + 15*2);
        end
        vectors++;
        if (nrd != 16 || uflow1 != 0) begin
            miscompares++;
            $display("FAIL fifo16_reads rd=%0d underflow=%0d want 16 and 0", nrd, uflow1);
        end
    endtask

    task automatic test_random;
        bit sel;
        int n, gap;
        for (int it = 0; it < 6; it++) begin
            sel = (it % 2 == 1);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
            n = $urandom_range(1, 4);
            stim_q.delete();
            for (int j = 0; j < n; j++) stim_q.push_back(8'($urandom));
            push_stim(sel);
            build_model(sel ? 2 : 1);
            capture(sel, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (cap_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL random_%0d cycle %0d got %b want %b", it, i, cap_q[i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (uflow1 != 0 || uflow2 != 0) begin
            miscompares++;
            $display("FAIL underflow got %0d/%0d want 0/0", uflow1, uflow2);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_reset_mid_frame();
        test_stop2();
        test_fifo16();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that drains bytes from the TX-side `sync_fifo` and serializes them onto the `tx` line. It drives the FIFO's read side: it reads one byte whenever the FIFO is non-empty and the transmitter is idle. Each byte is sent as a standard 8N1/8N2 frame: a start bit, the data bits LSB first, then the stop bits. It sits between the TX FIFO and the board-level `tx` pin, mirroring the receive path.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: bits per frame; must match the FIFO's `DATA_WIDTH`.
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200): clock cycles per bit; must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 and 2.

Ports:
- `clk`  in  1  system clock; the block uses one clock only.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO read data; valid in the cycle after an accepted read.
- `fifo_rd_req`  out  1  FIFO read request; a one-cycle pulse per byte.
- `tx`  out  1  serial line; idles high; registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx_done`  out  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation

- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - `tx`=1.
  - If `fifo_empty`=0, go to FETCH.
- FETCH:
  - `fifo_rd_req`=1 for exactly this cycle. This is a Moore output; it is never asserted in any other state.
  - Go to LOAD.
- LOAD:
  - Capture `fifo_data` into the shift register.
  - Clear the bit-timer and bit index.
  - Go to START.
- START:
  - `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx`=shreg[0] for CLKS_PER_BIT cycles.
  - Then shift right and increment the bit index.
  - After bit DATA_WIDTH-1, go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - In the final cycle, pulse `tx_done`.
  - Next state is FETCH if `fifo_empty`=0, else IDLE.
- Bit-timer width is $clog2(CLKS_PER_BIT). Bit-index width is $clog2(DATA_WIDTH). Stop-bit counting reuses the bit-timer plus a 1-bit stop index.
- The FIFO input is never sampled outside IDLE, the final STOP cycle and LOAD. Writes into the FIFO during a frame do not disturb it.
- Reset (any state, including mid-frame):
  - At the next edge: state=IDLE, `tx`=1, `busy`=0, `tx_done`=0, `fifo_rd_req`=0, counters=0.
  - A byte already popped is discarded; it is not re-read.

## Timing

- Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_rd_req`=0.
- Let E0 be the edge at which IDLE samples `fifo_empty`=0.
  - The state is FETCH after E0.
  - The FIFO is read at E1.
  - `fifo_data` is captured at E2, and `tx` goes low after E2.
- Frame length from the `tx` falling edge to the end of the stop bits is (1+DATA_WIDTH+STOP_BITS)×CLKS_PER_BIT cycles.
- Back-to-back frames: the gap between the end of the stop bits and the next start bit is exactly 2 cycles of `tx`=1 (FETCH, LOAD). No extra IDLE cycle is inserted.
- `busy` rises the cycle after E0 and falls the cycle after the `tx_done` pulse, unless the next frame chains.
- The block never issues a read while `fifo_empty`=1, so a read can never underflow the FIFO.

## Structure

- Shared package `uart_pkg`:
  - `tx_state_t`, the enum of the six states.
  - Default baud constant `UART_CLKS_PER_BIT`=868.
  - Shared with the receiver.
- One natural sub-module: `uart_bit_timer`.
  - A CLKS_PER_BIT down-counter with a `clear` input and a `bit_tick` output.
  - Reusable by `uart_rx`.
- The FSM, shift register and bit/stop indices live in `uart_tx`.

## Test plan

All scenarios use CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1 unless noted.
- Reset held 3 cycles, then released with the FIFO empty → `tx`=1, `busy`=0 and `fifo_rd_req`=0 for 100 cycles.
- One byte 0xA5 pushed →
  - Exactly one `fifo_rd_req` pulse.
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each value 4 cycles wide, i.e. 40 cycles in total.
  - `tx_done` pulses once, on the 40th cycle.
- 0x00 and 0xFF pushed back-to-back →
  - Two frames separated by exactly 2 high cycles.
  - Two read pulses and two `tx_done` pulses.
  - `busy` stays high throughout.
- Reset asserted in DATA bit 3 while 0x3C is being sent, with 0x81 still queued →
  - `tx`=1 the cycle after reset.
  - After release, 0x81 is sent completely.
  - 0x3C is not resent.
- STOP_BITS=2, byte 0x55 → the stop high period is 8 cycles and the frame is 44 cycles.
- FIFO filled with 16 bytes (0x00–0x0F) →
  - All 16 are transmitted in order.
  - Total span is 16×40+15×2 cycles.
  - `fifo_rd_req` is never asserted with `fifo_empty`=1.
